seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 8-digit common-anode seven-segment display. It splits a 32-bit value into eight nibbles (nibble i maps to digit i) and holds them in double-buffered display registers. It walks one digit at a time, with a blank gap between digits for anti-ghosting, and decodes each nibble to active-low segments. Sits between the top-level data source and the board display pins; new values commit only at frame boundaries, through a load/ack handshake.

---
 rtl/seg7_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller.
// Double-buffered display registers commit only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int GAP      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] hexs,
    input  logic [7:0]  points,
    input  logic [7:0]  blank,
    input  logic        load,
    output logic        load_ack,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int MAXC = (SCAN_DIV > GAP) ? SCAN_DIV : GAP;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [0:0] S_GAP  = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]    r_state;
    logic [2:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_an;
    logic [7:0]    r_seg;
    logic          r_frame_done;
    logic          r_load_ack;
    logic          r_pending;

    logic [31:0]   r_stg_hex;
    logic [7:0]    r_stg_pts;
    logic [7:0]    r_stg_blk;
    logic [31:0]   r_dsp_hex;
    logic [7:0]    r_dsp_pts;
    logic [7:0]    r_dsp_blk;

    logic          w_gap_end;
    logic          w_scan_end;
    logic          w_boundary;
    logic [3:0]    w_nib;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_gap_end  = (r_state == S_GAP)  && (r_cnt == CW'(GAP - 1));
    assign w_scan_end = (r_state == S_SCAN) && (r_cnt == CW'(SCAN_DIV - 1));
    assign w_boundary = w_scan_end && (r_idx == 3'd7);
    assign w_nib      = r_dsp_hex[{r_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_GAP;
            r_idx        <= 3'd0;
            r_cnt        <= '0;
            r_an         <= 8'hFF;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_GAP: begin
                    if (w_gap_end) begin
                        r_state <= S_SCAN;
                        r_cnt   <= '0;
                        if (r_dsp_blk[r_idx]) begin
                            r_an  <= 8'hFF;
                            r_seg <= 8'hFF;
                        end else begin
                            r_an  <= ~(8'd1 << r_idx);
                            r_seg <= {~r_dsp_pts[r_idx], dec7(w_nib)};
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SCAN: begin
                    if (w_scan_end) begin
                        r_state      <= S_GAP;
                        r_cnt        <= '0;
                        r_idx        <= r_idx + 3'd1;
                        r_an         <= 8'hFF;
                        r_seg        <= 8'hFF;
                        r_frame_done <= (r_idx == 3'd7);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_GAP;
                    r_cnt   <= '0;
                    r_an    <= 8'hFF;
                    r_seg   <= 8'hFF;
                end
            endcase
        end
    end

    // A load in the boundary cycle lands in staging but stays pending.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending  <= 1'b0;
            r_load_ack <= 1'b0;
            r_stg_hex  <= '0;
            r_stg_pts  <= '0;
            r_stg_blk  <= '0;
            r_dsp_hex  <= '0;
            r_dsp_pts  <= '0;
            r_dsp_blk  <= '0;
        end else begin
            r_load_ack <= 1'b0;
            if (load) begin
                r_stg_hex <= hexs;
                r_stg_pts <= points;
                r_stg_blk <= blank;
            end
            if (w_boundary && r_pending) begin
                r_dsp_hex  <= r_stg_hex;
                r_dsp_pts  <= r_stg_pts;
                r_dsp_blk  <= r_stg_blk;
                r_load_ack <= 1'b1;
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;
    assign load_ack   = r_load_ack;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4, GAP=2.
// Each frame is checked cycle by cycle against hand-derived digit slots.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rstn;
    logic [31:0] hexs;
    logic [7:0]  points;
    logic [7:0]  blank;
    logic        load;
    logic        load_ack;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int n_checks;
    int n_errors;

    logic [6:0] tbl [16];

    seg7_scan_ctrl #(.SCAN_DIV(4), .GAP(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hexs       (hexs),
        .points     (points),
        .blank      (blank),
        .load       (load),
        .load_ack   (load_ack),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Frame slot k (edge k after frame start): GAP 2 edges, SCAN 4 edges.
    task automatic run_frame(input string       tag,
                             input logic [31:0] hx,
                             input logic [7:0]  pt,
                             input logic [7:0]  bk,
                             input logic        ack_exp,
                             input int          stop_k,
                             input int          l1_k,
                             input logic [31:0] l1_hx,
                             input logic [7:0]  l1_pt,
                             input logic [7:0]  l1_bk,
                             input int          l2_k,
                             input logic [31:0] l2_hx);
        logic [15:0] exp_as;
        logic [1:0]  exp_fa;
        int j, d, off;
        for (int k = 1; k <= stop_k; k++) begin
            if (k == l1_k) begin
                load = 1'b1; hexs = l1_hx;
                points = l1_pt; blank = l1_bk;
            end else if (k == l2_k) begin
                load = 1'b1; hexs = l2_hx;
                points = 8'h00; blank = 8'h00;
            end else begin
                load = 1'b0;
            end
            @(posedge clk);
            #1;
            load = 1'b0;
            exp_as = 16'hFFFF;
            if (k >= 2) begin
                j = k - 2;
                d = j / 6;
                off = j % 6;
                if (off < 4 && d < 8 && !bk[d]) begin
                    exp_as[15:8] = ~(8'd1 << d);
                    exp_as[7:0]  = {~pt[d], tbl[hx[d*4 +: 4]]};
                end
            end
            exp_fa = (k == 48) ? {1'b1, ack_exp} : 2'b00;
            check($sformatf("%s k%0d an_seg", tag, k),
                  {16'h0, an, seg}, {16'h0, exp_as});
            check($sformatf("%s k%0d fd_ack", tag, k),
                  {30'h0, frame_done, load_ack}, {30'h0, exp_fa});
        end
    endtask

    initial begin
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        n_checks = 0;
        n_errors = 0;
        rstn   = 1'b0;
        hexs   = '0;
        points = '0;
        blank  = '0;
        load   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst an", {24'h0, an}, 32'hFF);
        check("rst seg", {24'h0, seg}, 32'hFF);
        check("rst ack", {31'h0, load_ack}, 32'h0);
        check("rst fd", {31'h0, frame_done}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        run_frame("f0", 32'h0, 8'h00, 8'h00, 1'b1, 48,
                  20, 32'h89ABCDEF, 8'h01, 8'h00, 0, 32'h0);
        run_frame("f1", 32'h89ABCDEF, 8'h01, 8'h00, 1'b1, 48,
                  10, 32'h11111111, 8'h00, 8'h00, 13, 32'h22222222);
        run_frame("f2", 32'h22222222, 8'h00, 8'h00, 1'b0, 48,
                  48, 32'h33333333, 8'h00, 8'hF0, 0, 32'h0);
        run_frame("f3", 32'h22222222, 8'h00, 8'h00, 1'b1, 48,
                  0, 32'h0, 8'h00, 8'h00, 0, 32'h0);
        run_frame("f4", 32'h33333333, 8'h00, 8'hF0, 1'b0, 48,
                  0, 32'h0, 8'h00, 8'h00, 0, 32'h0);
        run_frame("f5", 32'h33333333, 8'h00, 8'hF0, 1'b0, 21,
                  5, 32'h44444444, 8'hFF, 8'h00, 0, 32'h0);

        check("pre-rst an d3", {24'h0, an}, 32'hF7);
        #2;
        rstn = 1'b0;
        #1;
        check("async an", {24'h0, an}, 32'hFF);
        check("async seg", {24'h0, seg}, 32'hFF);
        check("async ack", {31'h0, load_ack}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        run_frame("r0", 32'h0, 8'h00, 8'h00, 1'b0, 48,
                  0, 32'h0, 8'h00, 8'h00, 0, 32'h0);
        run_frame("r1", 32'h0, 8'h00, 8'h00, 1'b0, 48,
                  0, 32'h0, 8'h00, 8'h00, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
